// File: rtl/mul_exec_pipe_pkg.sv
// mul_exec_pipe_pkg: shared backend types and ROB age compare
package mul_exec_pipe_pkg;
  localparam int ROB_IDX_MAX = 16;
  localparam int PREG_W_DEF = 7;
  localparam int ROB_IDX_W_DEF = 6;
  typedef enum logic [1:0] {MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11} mul_op_e;
  typedef logic [PREG_W_DEF-1:0] preg_t;
  typedef struct packed {
    logic wrap;
    logic [ROB_IDX_W_DEF-1:0] idx;
  } rob_tag_t;
  function automatic logic rob_younger(input logic a_wrap, input logic [ROB_IDX_MAX-1:0] a_idx,
                                       input logic k_wrap, input logic [ROB_IDX_MAX-1:0] k_idx);
    return (a_wrap == k_wrap) ? (a_idx > k_idx) : (a_idx < k_idx);
  endfunction
endpackage

// File: rtl/mul_exec_pipe_core.sv
// mul_core: RV32M-style operand extension, full product and op-based result select
module mul_core
  import mul_exec_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mul_op_e          op,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  output logic [XLEN-1:0]  result
);
  localparam int PW = 2 * XLEN + 2;
  logic [XLEN:0] a, b;
  logic [PW-1:0] p;
  always_comb begin
    a = {(op != MULHU) & src1[XLEN-1], src1};
    b = {(op == MUL || op == MULH) & src2[XLEN-1], src2};
    p = {{(XLEN+1){a[XLEN]}}, a} * {{(XLEN+1){b[XLEN]}}, b};
    result = (op == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  end
endmodule

// File: rtl/mul_exec_pipe.sv
// mul_exec_pipe: pipelined multiply with payload tracking, global stall and ROB-tag kill
module mul_exec_pipe
  import mul_exec_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LATENCY = 3,
  parameter int PREG_W = 7,
  parameter int ROB_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [XLEN-1:0]      in_src1,
  input  logic [XLEN-1:0]      in_src2,
  input  logic [PREG_W-1:0]    in_pdst,
  input  logic [ROB_IDX_W:0]   in_rob_tag,
  input  logic                 kill_valid,
  input  logic [ROB_IDX_W:0]   kill_rob_tag,
  input  logic                 flush_all,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [PREG_W-1:0]    out_pdst,
  output logic [ROB_IDX_W:0]   out_rob_tag
);
  localparam int TW = ROB_IDX_W + 1;
  logic [LATENCY-1:0] v, v_n, hit;
  logic [XLEN-1:0] res [LATENCY];
  logic [PREG_W-1:0] pdst [LATENCY];
  logic [TW-1:0] tag [LATENCY];
  logic [XLEN-1:0] prod;
  logic stall, accept;
  function automatic logic younger(input logic [TW-1:0] a, input logic [TW-1:0] k);
    return rob_younger(a[TW-1], ROB_IDX_MAX'(a[ROB_IDX_W-1:0]), k[TW-1], ROB_IDX_MAX'(k[ROB_IDX_W-1:0]));
  endfunction
  if (LATENCY < 1 || LATENCY > 8) begin : g_lat_chk
    $error("mul_exec_pipe: LATENCY must be 1..8");
  end
  mul_core #(.XLEN(XLEN)) u_core (
    .op(mul_op_e'(in_op)),
    .src1(in_src1),
    .src2(in_src2),
    .result(prod)
  );
  assign stall = v[LATENCY-1] && !out_ready;
  assign in_ready = !stall;
  assign accept = in_valid && !stall && !flush_all && !(kill_valid && younger(in_rob_tag, kill_rob_tag));
  assign out_valid = v[LATENCY-1];
  assign out_result = res[LATENCY-1];
  assign out_pdst = pdst[LATENCY-1];
  assign out_rob_tag = tag[LATENCY-1];
  // kill is applied to each stage's current tag, whether or not the pipe advances
  always_comb begin
    for (int i = 0; i < LATENCY; i++) hit[i] = kill_valid && younger(tag[i], kill_rob_tag);
    v_n[0] = stall ? v[0] && !hit[0] : accept;
    for (int i = 1; i < LATENCY; i++) v_n[i] = stall ? v[i] && !hit[i] : v[i-1] && !hit[i-1];
    if (flush_all) v_n = '0;
  end
  always_ff @(posedge clk) begin
    v <= rst ? '0 : v_n;
    if (!stall) begin
      res[0] <= prod;
      pdst[0] <= in_pdst;
      tag[0] <= in_rob_tag;
      for (int i = 1; i < LATENCY; i++) begin
        res[i] <= res[i-1];
        pdst[i] <= pdst[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end
  always_ff @(posedge clk) if (!rst && out_valid) assert (!$isunknown({out_result, out_pdst, out_rob_tag}));
endmodule

// File: tb/tb_mul_exec_pipe.sv
// tb_mul_exec_pipe: queue-based reference model, per-cycle compare, directed and random stimulus
module tb_mul_exec_pipe;
  localparam int L = 3;
  logic clk = 0, rst = 1, in_valid = 0, kill_valid = 0, flush_all = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [1:0] in_op = 0;
  logic [31:0] in_src1 = 0, in_src2 = 0, out_result;
  logic [6:0] in_pdst = 0, in_rob_tag = 0, kill_rob_tag = 0, out_pdst, out_rob_tag;
  always #5 clk = ~clk;

  mul_exec_pipe #(.XLEN(32), .LATENCY(L), .PREG_W(7), .ROB_IDX_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_pdst(in_pdst), .in_rob_tag(in_rob_tag),
    .kill_valid(kill_valid), .kill_rob_tag(kill_rob_tag), .flush_all(flush_all),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_pdst(out_pdst), .out_rob_tag(out_rob_tag)
  );

  typedef struct {
    logic [31:0] res;
    logic [6:0] pdst;
    logic [6:0] tag;
    int rem;
  } ent_t;
  ent_t q[$];
  logic [6:0] ret_tags[$];
  logic [31:0] ret_res[$];
  int checks = 0, failures = 0;
  bit en = 0;

  function automatic logic younger(input logic [6:0] a, input logic [6:0] k);
    return (a[6] == k[6]) ? (a[5:0] > k[5:0]) : (a[5:0] < k[5:0]);
  endfunction

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    x = (op == 2'd3) ? longint'({32'd0, a}) : longint'(signed'(a));
    y = op[1] ? longint'({32'd0, b}) : longint'(signed'(b));
    p = x * y;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: in-flight uops ordered oldest first, rem = cycles until output
  always @(posedge clk) begin
    logic st, acc;
    if (rst || flush_all) q.delete();
    else begin
      st = q.size() > 0 && q[0].rem == 0 && !out_ready;
      acc = in_valid && !st && !(kill_valid && younger(in_rob_tag, kill_rob_tag));
      if (kill_valid)
        for (int i = q.size() - 1; i >= 0; i--) if (younger(q[i].tag, kill_rob_tag)) q.delete(i);
      if (!st) begin
        if (q.size() > 0 && q[0].rem == 0) void'(q.pop_front());
        foreach (q[i]) q[i].rem--;
        if (acc) q.push_back('{ref_mul(in_op, in_src1, in_src2), in_pdst, in_rob_tag, L - 1});
      end
    end
  end

  always @(negedge clk) if (en) begin
    logic ev;
    ev = q.size() > 0 && q[0].rem == 0;
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(!(ev && !out_ready)));
    if (ev && out_valid) begin
      chk("out_result", 64'(out_result), 64'(q[0].res));
      chk("out_pdst", 64'(out_pdst), 64'(q[0].pdst));
      chk("out_rob_tag", 64'(out_rob_tag), 64'(q[0].tag));
    end
    if (out_valid && out_ready && !rst && !flush_all && !(kill_valid && younger(out_rob_tag, kill_rob_tag))) begin
      ret_tags.push_back(out_rob_tag);
      ret_res.push_back(out_result);
    end
  end

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] pd, input logic [6:0] tg);
    in_valid = v; in_op = op; in_src1 = a; in_src2 = b; in_pdst = pd; in_rob_tag = tg;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, sent;
    logic acc;
    logic [6:0] cnt;
    logic [1:0] ops [4] = '{2'd1, 2'd3, 2'd2, 2'd1};
    logic [31:0] sa [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] ex [4] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
    @(posedge clk); #1 en = 1; #1;
    step();
    rst = 0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    step();
    // model pins
    chk("model_mul", 64'(ref_mul(2'd0, 32'd7, 32'd6)), 64'd42);
    chk("model_mulhu", 64'(ref_mul(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'hFFFFFFFE);
    chk("model_mulhsu", 64'(ref_mul(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'hFFFFFFFF);
    // MUL 7x6 latency
    drive(1, 2'd0, 32'd7, 32'd6, 7'd9, 7'd5);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (L - 1) step();
    @(negedge clk);
    chk("mul_lat_valid", 64'(out_valid), 64'd1);
    chk("mul_lat_result", 64'(out_result), 64'd42);
    chk("mul_lat_pdst", 64'(out_pdst), 64'd9);
    chk("mul_lat_tag", 64'(out_rob_tag), 64'd5);
    step();
    // high-half ops
    base = ret_res.size();
    for (int k = 0; k < 4; k++) begin
      drive(1, ops[k], sa[k], sa[k], 7'(k), 7'(10 + k));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (L + 2) step();
    chk("ops_count", 64'(ret_res.size() - base), 64'd4);
    for (int k = 0; k < 4; k++) if (base + k < ret_res.size()) chk("ops_result", 64'(ret_res[base + k]), 64'(ex[k]));
    // stream of 5 with a 4-cycle stall
    base = ret_tags.size();
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= L && c < L + 4);
      if (sent < 5) drive(1, 2'($urandom), $urandom, $urandom, 7'(sent), 7'(20 + sent));
      else drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == L + 1) chk("stall_in_ready", 64'(in_ready), 64'd0);
      step();
      if (acc) sent++;
    end
    chk("stream_count", 64'(ret_tags.size() - base), 64'd5);
    for (int k = 0; k < 5; k++) if (base + k < ret_tags.size()) chk("stream_order", 64'(ret_tags[base + k]), 64'(20 + k));
    // selective kill
    out_ready = 1;
    base = ret_tags.size();
    drive(1, 2'd0, 32'd2, 32'd3, 7'd1, 7'h03); step();
    drive(1, 2'd0, 32'd4, 32'd5, 7'd2, 7'h05); step();
    drive(1, 2'd0, 32'd6, 32'd7, 7'd3, 7'h41); step();
    drive(1, 2'd0, 32'd8, 32'd9, 7'd4, 7'h04);
    kill_valid = 1; kill_rob_tag = 7'h04;
    step();
    kill_valid = 0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (L + 2) step();
    chk("kill_count", 64'(ret_tags.size() - base), 64'd2);
    if (ret_tags.size() >= base + 2) begin
      chk("kill_survivor", 64'(ret_tags[base]), 64'h03);
      chk("kill_equal_tag", 64'(ret_tags[base + 1]), 64'h04);
    end
    // flush while stalled
    out_ready = 0;
    base = ret_tags.size();
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'd0, 32'(k), 32'd3, 7'(k), 7'(30 + k));
      step();
    end
    flush_all = 1;
    drive(1, 2'd0, 32'd1, 32'd1, 7'd5, 7'd40);
    step();
    flush_all = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1;
    repeat (L + 2) step();
    chk("flush_no_output", 64'(ret_tags.size() - base), 64'd0);
    // reset mid-operation
    base = ret_tags.size();
    drive(1, 2'd0, 32'd5, 32'd5, 7'd1, 7'd50); step();
    drive(1, 2'd0, 32'd6, 32'd6, 7'd2, 7'd51); step();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1;
    step();
    rst = 0;
    repeat (L + 2) step();
    chk("rst_no_output", 64'(ret_tags.size() - base), 64'd0);
    drive(1, 2'd0, 32'd3, 32'd3, 7'd7, 7'd52);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (L - 1) step();
    @(negedge clk);
    chk("rst_new_valid", 64'(out_valid), 64'd1);
    chk("rst_new_result", 64'(out_result), 64'd9);
    step();
    // randomized traffic
    cnt = 7'd60;
    for (int c = 0; c < 600; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
      drive($urandom_range(0, 3) != 0, 2'($urandom),
            ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
            ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom, 7'($urandom), cnt);
      kill_valid = $urandom_range(0, 15) == 0;
      kill_rob_tag = 7'(cnt - 7'($urandom_range(1, 6)));
      flush_all = $urandom_range(0, 63) == 0;
      step();
      cnt = cnt + 7'd1;
    end
    drive(0, 0, 0, 0, 0, 0);
    kill_valid = 0; flush_all = 0; out_ready = 1;
    repeat (L + 3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
